// File: rtl/spi_regmap_pkg.sv
// Shared types and constants for the SPI register-map slave.
package spi_regmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INST = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } state_e;

    localparam logic INST_READ  = 1'b1;
    localparam logic INST_WRITE = 1'b0;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for the SPI pins plus sck/cs_n edge detection in clk.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic sdi,
    input  logic cs_n,
    output logic sdi_s,
    output logic cs_n_s,
    output logic sck_rise_c,
    output logic sck_fall_c,
    output logic cs_fall_c
);

    logic [2:0] sck_q, sck_d;
    logic [1:0] sdi_q, sdi_d;
    logic [2:0] cs_q, cs_d;

    always_comb begin
        sck_d = {sck_q[1:0], sck};
        sdi_d = {sdi_q[0], sdi};
        cs_d  = {cs_q[1:0], cs_n};
    end

    // cs chain resets to "selected" so a cs_n already low at release is not seen as a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q <= '0;
            sdi_q <= '0;
            cs_q  <= '0;
        end else begin
            sck_q <= sck_d;
            sdi_q <= sdi_d;
            cs_q  <= cs_d;
        end
    end

    assign sdi_s      = sdi_q[1];
    assign cs_n_s     = cs_q[1];
    assign sck_rise_c = sck_q[1] & ~sck_q[2];
    assign sck_fall_c = ~sck_q[1] & sck_q[2];
    assign cs_fall_c  = ~cs_q[1] & cs_q[2];

endmodule

// File: rtl/spi_regmap_burst.sv
// SPI mode-0 slave exposing config (R/W) and status (RO) registers.
// Define SPI_REGMAP_BURST_EN to keep streaming words with auto-increment while cs_n stays low.
module spi_regmap_burst #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CFG    = 96,
    parameter int unsigned NUM_STAT   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sck,
    input  logic                           sdi,
    input  logic                           cs_n,
    output logic                           sdo,
    output logic                           sdo_oe,
    output logic [NUM_CFG*DATA_WIDTH-1:0]  cfg_o,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_i,
    output logic                           wr_stb,
    output logic [ADDR_WIDTH-1:0]          wr_addr
);

    import spi_regmap_pkg::*;

    localparam int unsigned NUM_REGS = NUM_CFG + NUM_STAT;
    localparam int unsigned CNT_W    = clog2_min1((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH);
    localparam int unsigned CFG_IW   = clog2_min1(NUM_CFG);
    localparam int unsigned STAT_IW  = clog2_min1(NUM_STAT);

    logic sdi_s, cs_n_s, sck_rise_c, sck_fall_c, cs_fall_c;

    spi_sync_edge u_sync (
        .clk        (clk),
        .rst        (rst),
        .sck        (sck),
        .sdi        (sdi),
        .cs_n       (cs_n),
        .sdi_s      (sdi_s),
        .cs_n_s     (cs_n_s),
        .sck_rise_c (sck_rise_c),
        .sck_fall_c (sck_fall_c),
        .cs_fall_c  (cs_fall_c)
    );

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    inst_q, inst_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic                    done_q, done_d;
    logic                    sdo_q, sdo_d;
    logic                    sdo_oe_q, sdo_oe_d;
    logic                    wr_stb_q, wr_stb_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   cfg_q [NUM_CFG];
    logic [DATA_WIDTH-1:0]   cfg_d [NUM_CFG];

    logic [ADDR_WIDTH-1:0]   addr_shift_c, addr_next_c, rd_addr_c;
    logic [DATA_WIDTH-1:0]   rd_word_c, rx_shift_c;

    // Read address is either the just-completed address or the next burst address.
    always_comb begin
        addr_shift_c = ADDR_WIDTH'({addr_q, sdi_s});
        addr_next_c  = (32'(addr_q) == NUM_REGS - 1) ? '0 : addr_q + ADDR_WIDTH'(1);
        rd_addr_c    = (state_q == ST_ADDR) ? addr_shift_c : addr_next_c;
        rx_shift_c   = DATA_WIDTH'({rx_q, sdi_s});
    end

    // Register lookup; status is sampled only at the moment this word is latched.
    always_comb begin
        rd_word_c = '0;
        if (32'(rd_addr_c) < NUM_CFG) begin
            rd_word_c = cfg_q[CFG_IW'(rd_addr_c)];
        end else if (32'(rd_addr_c) < NUM_REGS) begin
            rd_word_c = stat_i[STAT_IW'(32'(rd_addr_c) - NUM_CFG) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inst_d    = inst_q;
        addr_d    = addr_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        done_d    = done_q;
        sdo_d     = sdo_q;
        sdo_oe_d  = ~cs_n_s & ((state_q != ST_IDLE) | cs_fall_c);
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        cfg_d     = cfg_q;

        if (cs_n_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rx_d    = '0;
            done_d  = 1'b0;
            sdo_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_c) begin
                        state_d = ST_INST;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        sdo_d   = 1'b0;
                    end
                end
                ST_INST: begin
                    if (sck_rise_c) begin
                        inst_d  = sdi_s;
                        cnt_d   = '0;
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_c) begin
                        addr_d = addr_shift_c;
                        if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                            if (inst_q == INST_READ) begin
                                tx_d  = rd_word_c;
                                sdo_d = rd_word_c[DATA_WIDTH-1];
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (!done_q) begin
                        if (sck_rise_c) begin
                            rx_d = rx_shift_c;
                            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                                cnt_d = '0;
                                if (inst_q == INST_WRITE && 32'(addr_q) < NUM_CFG) begin
                                    cfg_d[CFG_IW'(addr_q)] = rx_shift_c;
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = addr_q;
                                end
`ifdef SPI_REGMAP_BURST_EN
                                addr_d = addr_next_c;
                                if (inst_q == INST_READ) begin
                                    tx_d  = rd_word_c;
                                    sdo_d = rd_word_c[DATA_WIDTH-1];
                                end
`else
                                done_d = 1'b1;
                                sdo_d  = 1'b0;
`endif
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        // The fall right after a word boundary keeps the freshly loaded MSB.
                        end else if (sck_fall_c && inst_q == INST_READ && cnt_q != '0) begin
                            tx_d  = DATA_WIDTH'({tx_q, 1'b0});
                            sdo_d = tx_d[DATA_WIDTH-1];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            inst_q    <= 1'b0;
            addr_q    <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            done_q    <= 1'b0;
            sdo_q     <= 1'b0;
            sdo_oe_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            cfg_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            addr_q    <= addr_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            sdo_q     <= sdo_d;
            sdo_oe_q  <= sdo_oe_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            cfg_q     <= cfg_d;
        end
    end

    assign sdo     = sdo_q;
    assign sdo_oe  = sdo_oe_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;

    for (genvar n = 0; n < NUM_CFG; n++) begin : g_cfg
        assign cfg_o[n*DATA_WIDTH +: DATA_WIDTH] = cfg_q[n];
    end

endmodule

// File: tb/tb_spi_regmap_burst.sv
// Self-checking bench for spi_regmap_burst (8-bit addresses, 96 config + 32 status registers).
module tb_spi_regmap_burst;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned NC   = 96;
    localparam int unsigned NS   = 32;
    localparam int unsigned NR   = NC + NS;
    localparam int unsigned HALF = 6;

    logic clk = 1'b0;
    logic rst, sck, sdi, cs_n;
    logic sdo, sdo_oe, wr_stb;
    logic [AW-1:0]    wr_addr;
    logic [NC*DW-1:0] cfg_o;
    logic [NS*DW-1:0] stat_i;

    int checks = 0;
    int failures = 0;
    int stb_cycles = 0;
    int stb_pulses = 0;
    logic stb_prev = 1'b0;
    logic [AW-1:0] last_wr_addr = '0;
    logic oe_all;

    logic [DW-1:0] cfg_m  [NC];
    logic [DW-1:0] stat_m [NS];

    always #5 clk = ~clk;

    spi_regmap_burst #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_CFG    (NC),
        .NUM_STAT   (NS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sck     (sck),
        .sdi     (sdi),
        .cs_n    (cs_n),
        .sdo     (sdo),
        .sdo_oe  (sdo_oe),
        .cfg_o   (cfg_o),
        .stat_i  (stat_i),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr)
    );

    // Strobe monitor: high-cycle count and rising-edge count.
    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cycles++;
            last_wr_addr = wr_addr;
            if (!stb_prev) stb_pulses++;
        end
        stb_prev = wr_stb;
    end

    function automatic logic [DW-1:0] model_read(input int a);
        if (a < int'(NC)) return cfg_m[a];
        if (a < int'(NR)) return stat_m[a - int'(NC)];
        return '0;
    endfunction

    function automatic logic [NC*DW-1:0] cfg_pack();
        logic [NC*DW-1:0] v;
        for (int i = 0; i < int'(NC); i++) v[i*DW +: DW] = cfg_m[i];
        return v;
    endfunction

    task automatic drive_stat();
        for (int i = 0; i < int'(NS); i++) stat_i[i*DW +: DW] = stat_m[i];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cfg(input string tag);
        logic [NC*DW-1:0] e;
        e = cfg_pack();
        checks++;
        assert (cfg_o === e) else begin
            failures++;
            $error("FAIL %s cfg_o=%h expected=%h", tag, cfg_o, e);
        end
    endtask

    // Mode-0 master: drive on the low phase, sample sdo at each rising sck.
    task automatic spi_xfer(input int nbits, input logic [63:0] mosi, output logic [63:0] miso);
        miso   = '0;
        oe_all = 1'b1;
        cs_n   = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = mosi[i];
            repeat (HALF) @(negedge clk);
            sck     = 1'b1;
            miso[i] = sdo;
            oe_all  = oe_all & sdo_oe;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        sdi  = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input string tag);
        logic [63:0] miso;
        int p0, c0, exp_n;
        p0 = stb_pulses;
        c0 = stb_cycles;
        spi_xfer(1 + AW + DW, 64'({1'b0, AW'(a), d}), miso);
        exp_n = (a < int'(NC)) ? 1 : 0;
        if (exp_n == 1) begin
            cfg_m[a] = d;
            check({tag, "_waddr"}, 64'(last_wr_addr), 64'(a));
        end
        check({tag, "_stb_pulses"}, 64'(stb_pulses - p0), 64'(exp_n));
        check({tag, "_stb_cycles"}, 64'(stb_cycles - c0), 64'(exp_n));
        check_cfg({tag, "_cfg"});
    endtask

    task automatic do_read(input int a, input string tag);
        logic [63:0] miso;
        logic [DW-1:0] e;
        e = model_read(a);
        spi_xfer(1 + AW + DW, 64'({1'b1, AW'(a), DW'(0)}), miso);
        check({tag, "_data"}, 64'(miso[DW-1:0]), 64'(e));
        check({tag, "_sdo_hdr"}, 64'(miso[DW+AW:DW]), 64'd0);
        check({tag, "_oe"}, 64'(oe_all), 64'd1);
    endtask

    initial begin
        logic [63:0] miso;
        logic [DW-1:0] exp8;
        logic [16:0] frame;
        int p0;

        rst  = 1'b1;
        sck  = 1'b0;
        sdi  = 1'b0;
        cs_n = 1'b1;
        for (int i = 0; i < int'(NC); i++) cfg_m[i] = '0;
        for (int i = 0; i < int'(NS); i++) stat_m[i] = DW'($urandom);
        drive_stat();
        repeat (4) @(negedge clk);
        check("rst_sdo", 64'(sdo), 64'd0);
        check("rst_oe", 64'(sdo_oe), 64'd0);
        check("rst_stb", 64'(wr_stb), 64'd0);
        check_cfg("rst_cfg");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        do_read(8'h00, "rd00_after_rst");
        do_write(8'h10, 8'h5A, "wr10");
        do_read(8'h10, "rd10");

        stat_m[0] = 8'hC3;
        drive_stat();
        do_read(8'h60, "rd60");
        do_write(8'h60, 8'h11, "wr60_ro");
        do_read(8'h60, "rd60_again");

        // Abort a write of 0xFF to 0x05 after 12 bits.
        do_write(8'h05, 8'h3C, "wr05");
        p0 = stb_pulses;
        spi_xfer(12, 64'({1'b0, 8'h05, 8'hFF}) >> 5, miso);
        check("abort_nostb", 64'(stb_pulses - p0), 64'd0);
        check_cfg("abort_cfg");
        do_read(8'h05, "abort_rd05");

        do_read(8'h90, "rd90_unmapped");
        do_write(8'h90, 8'h77, "wr90_unmapped");
        do_write(8'h5F, DW'($urandom), "wr5f_last_cfg");
        do_read(8'h5F, "rd5f");
        do_read(8'h7F, "rd7f_last_stat");
        do_read(8'hFF, "rdff_unmapped");
        do_write(8'h00, 8'h77, "wr00");

        // Status must be captured when the address completes, not during shift-out.
        stat_m[1] = 8'h96;
        drive_stat();
        exp8 = model_read(8'h61);
        fork
            begin
                repeat ((1 + AW + 2) * 2 * HALF) @(negedge clk);
                stat_m[1] = 8'h69;
                drive_stat();
            end
        join_none
        spi_xfer(1 + AW + DW, 64'({1'b1, 8'h61, 8'h00}), miso);
        check("stat_snapshot", 64'(miso[DW-1:0]), 64'(exp8));
        do_read(8'h61, "stat_updated");

        // Reset in the middle of a frame, then keep clocking with cs_n still low.
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            sdi = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        rst = 1'b1;
        for (int i = 0; i < int'(NC); i++) cfg_m[i] = '0;
        repeat (3) @(negedge clk);
        check("midrst_oe", 64'(sdo_oe), 64'd0);
        check("midrst_sdo", 64'(sdo), 64'd0);
        check_cfg("midrst_cfg");
        rst = 1'b0;
        p0 = stb_pulses;
        frame = {1'b0, 8'h10, 8'hEE};
        for (int i = 16; i >= 0; i--) begin
            sdi = frame[i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("midrst_nostb", 64'(stb_pulses - p0), 64'd0);
        check_cfg("midrst_after_cfg");
        do_read(8'h10, "rd10_after_midrst");
        do_write(8'h00, 8'h77, "wr00_again");

`ifdef SPI_REGMAP_BURST_EN
        p0 = stb_pulses;
        spi_xfer(1 + AW + 2 * DW, 64'({1'b0, 8'h5F, 8'hAA, 8'hBB}), miso);
        cfg_m[8'h5F] = 8'hAA;
        check("burst_wr_stb", 64'(stb_pulses - p0), 64'd1);
        check("burst_wr_addr", 64'(last_wr_addr), 64'h5F);
        check_cfg("burst_wr_cfg");
        do_read(8'h60, "burst_rd60");
        spi_xfer(1 + AW + 2 * DW, 64'({1'b1, 8'h7F, 16'h0000}), miso);
        check("burst_rd_w0", 64'(miso[15:8]), 64'(stat_m[31]));
        check("burst_rd_wrap", 64'(miso[7:0]), 64'(cfg_m[0]));
`else
        p0 = stb_pulses;
        spi_xfer(1 + AW + 2 * DW, 64'({1'b0, 8'h20, 8'hAA, 8'hBB}), miso);
        cfg_m[8'h20] = 8'hAA;
        check("single_wr_stb", 64'(stb_pulses - p0), 64'd1);
        check("single_wr_addr", 64'(last_wr_addr), 64'h20);
        check_cfg("single_wr_cfg");
        spi_xfer(1 + AW + 2 * DW, 64'({1'b1, 8'h7F, 16'h0000}), miso);
        check("single_rd_w0", 64'(miso[15:8]), 64'(stat_m[31]));
        check("single_rd_tail", 64'(miso[7:0]), 64'd0);
`endif

        for (int n = 0; n < 24; n++) begin
            int ra;
            ra = $urandom_range(0, 159);
            stat_m[$urandom_range(0, NS - 1)] = DW'($urandom);
            drive_stat();
            if ($urandom_range(0, 1) == 1) do_write(ra, DW'($urandom), "rnd_wr");
            else do_read(ra, "rnd_rd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
